// File: rtl/usb_pkg.sv
// Shared USB clocking definitions: sequencer state encoding and default timing constants.
package usb_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } usb_state_e;

  localparam int CLK_HZ = 48_000_000;

  // 100 us of stable lock and a 1 ms frame period at 48 MHz
  localparam int LOCK_STABLE_CYCLES_DEFAULT = 4800;
  localparam int MS_CYCLES_DEFAULT          = 48000;

endpackage

// File: rtl/usb_sync2.sv
// Two-flop synchroniser for asynchronous single-bit inputs, with synchronous clear.
module usb_sync2 (
  input  logic clk,
  input  logic clear,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (clear) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/usb_clk_rst_gen.sv
// USB-domain reset sequencer and 12 MHz / 1 ms strobe generator running on clk48mhz.
//   state     | meaning
//   WAIT_LOCK | PLL not locked (synchronised), USB domain held in reset
//   SETTLE    | lock seen, counting LOCK_STABLE_CYCLES of uninterrupted lock
//   RUN       | reset released, strobes running
module usb_clk_rst_gen
  import usb_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = LOCK_STABLE_CYCLES_DEFAULT,
  parameter int MS_CYCLES          = MS_CYCLES_DEFAULT
) (
  input  logic clk48mhz,
  input  logic reset,
  input  logic clk_locked,
  output logic usb_rst,
  output logic ce_12mhz,
  output logic ms_tick
);

  localparam int CNT_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int MS_W  = $clog2(MS_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(MS_CYCLES - 1);

  usb_state_e       state_q;
  usb_state_e       state_d;
  logic             lock_s;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       div;
  logic [MS_W-1:0]  ms_cnt;
  logic             running;

  usb_sync2 u_lock_sync (
    .clk   (clk48mhz),
    .clear (reset),
    .d     (clk_locked),
    .q     (lock_s)
  );

  always_ff @(posedge clk48mhz) begin
    if (reset) state_q <= WAIT_LOCK;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_LOCK: if (lock_s) state_d = SETTLE;
      SETTLE: begin
        if (!lock_s)              state_d = WAIT_LOCK;
        else if (cnt == CNT_LAST) state_d = RUN;
      end
      RUN:       if (!lock_s) state_d = WAIT_LOCK;
      default:   state_d = WAIT_LOCK;
    endcase
  end

  always_comb begin
    usb_rst = (state_q != RUN);
    running = (state_q == RUN) && (state_d == RUN);
  end

  // Any break in SETTLE drops the count so a glitch restarts the full settle time.
  always_ff @(posedge clk48mhz) begin
    if (reset)                                      cnt <= '0;
    else if ((state_q == SETTLE) && (state_d == SETTLE)) cnt <= cnt + 1'b1;
    else                                            cnt <= '0;
  end

  // Strobes are cleared on the same edge that leaves RUN so none trails usb_rst.
  always_ff @(posedge clk48mhz) begin
    if (reset || !running) begin
      div      <= 2'd0;
      ms_cnt   <= '0;
      ce_12mhz <= 1'b0;
      ms_tick  <= 1'b0;
    end else begin
      div      <= div + 2'd1;
      ms_cnt   <= (ms_cnt == MS_LAST) ? '0 : ms_cnt + 1'b1;
      ce_12mhz <= (div == 2'd3);
      ms_tick  <= (ms_cnt == MS_LAST);
    end
  end

endmodule
